// File: rtl/prog_host_ctrl_if.sv
// Host-side bundle for prog_host_ctrl: job control, operand/result streams,
// core launch handshake and the shared data-memory port.
interface prog_host_ctrl_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          go;
    logic          busy;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          core_start;
    logic          core_halt;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          done;
    logic          timeout_err;

    modport master (
        input  go, in_valid, in_data, out_ready, core_halt, mem_rd_data,
        output busy, in_ready, out_valid, out_data, core_start, mem_sel,
               mem_addr, mem_wr_en, mem_wr_data, done, timeout_err
    );

    modport slave (
        output go, in_valid, in_data, out_ready, core_halt, mem_rd_data,
        input  busy, in_ready, out_valid, out_data, core_start, mem_sel,
               mem_addr, mem_wr_en, mem_wr_data, done, timeout_err
    );
endinterface

// File: rtl/prog_host_ctrl.sv
// Host sequencer: loads operands into data memory, launches the core via start/halt,
// then streams result bytes back out. Owns the memory port whenever the core is held.
module prog_host_ctrl #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned LOAD_BASE   = 8,
    parameter int unsigned LOAD_LEN    = 4,
    parameter int unsigned RESULT_BASE = 8,
    parameter int unsigned RESULT_LEN  = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 4096
) (
    input logic            clk_i,
    input logic            rst_ni,
    prog_host_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StLaunch, StRun, StRdAddr, StRdOut
    } state_e;

    state_e        state_q;
    logic [15:0]   idx_q;
    logic [15:0]   cnt_q;
    logic          busy_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_hold_q;
    logic [DW-1:0] out_data_q;
    logic          core_start_q;
    logic          mem_sel_q;
    logic          done_q;
    logic          timeout_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_hold_q    <= 1'b0;
            out_data_q    <= '0;
            core_start_q  <= 1'b1;
            mem_sel_q     <= 1'b1;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.go) begin
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        timeout_err_q <= 1'b0;
                        idx_q         <= '0;
                        cnt_q         <= '0;
                        if (LOAD_LEN == 0) begin
                            mem_sel_q <= 1'b0;
                            state_q   <= StLaunch;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        idx_q <= idx_q + 16'd1;
                        if (idx_q == 16'(LOAD_LEN - 1)) begin
                            in_ready_q <= 1'b0;
                            mem_sel_q  <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
                        cnt_q        <= '0;
                        core_start_q <= 1'b0;
                        state_q      <= StRun;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    // Halt takes priority over a coincident timeout.
                    if (bus.core_halt) begin
                        core_start_q <= 1'b1;
                        mem_sel_q    <= 1'b1;
                        idx_q        <= '0;
                        state_q      <= StRdAddr;
                    end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        core_start_q  <= 1'b1;
                        mem_sel_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StRdAddr: begin
                    out_valid_q <= 1'b1;
                    out_hold_q  <= 1'b0;
                    state_q     <= StRdOut;
                end
                StRdOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_hold_q  <= 1'b0;
                        idx_q       <= idx_q + 16'd1;
                        if (idx_q == 16'(RESULT_LEN - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StRdAddr;
                        end
                    end else if (!out_hold_q) begin
                        // Freeze the byte so it cannot move while the sink stalls.
                        out_hold_q <= 1'b1;
                        out_data_q <= bus.mem_rd_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] out_data;

    always_comb begin
        mem_addr = '0;
        if (state_q == StLoad) begin
            mem_addr = AW'(LOAD_BASE) + AW'(idx_q);
        end else if (state_q == StRdAddr || state_q == StRdOut) begin
            mem_addr = AW'(RESULT_BASE) + AW'(idx_q);
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid_q) begin
            out_data = out_hold_q ? out_data_q : bus.mem_rd_data;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data;
    assign bus.core_start  = core_start_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_en   = in_ready_q & bus.in_valid;
    assign bus.mem_wr_data = in_ready_q ? bus.in_data : '0;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prog_host_ctrl.sv
// Directed bench for prog_host_ctrl with a memory/core model and scoreboard queues
// for memory writes and result bytes.
module tb_prog_host_ctrl;

    typedef logic [7:0] ops_t [4];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_host_ctrl_if #(.AW(8), .DW(8)) bus ();
    prog_host_ctrl_if #(.AW(8), .DW(8)) bus2 ();

    prog_host_ctrl #(.LOAD_BASE(8), .RESULT_BASE(8), .TIMEOUT(64)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    prog_host_ctrl #(.LOAD_BASE(254), .RESULT_BASE(254), .TIMEOUT(64)) u_dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    // Memory and core model: core writes 0x0F to addr 11 and halts 20 cycles into a run.
    logic [7:0] mem [256];
    logic [7:0] rd_data;
    logic       model_halt;
    logic [7:0] run_cnt;
    int         core_mode;
    logic       force_halt;

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        if (bus.core_start) begin
            run_cnt    <= 8'd0;
            model_halt <= 1'b0;
        end else if (core_mode == 0) begin
            run_cnt <= run_cnt + 8'd1;
            if (run_cnt == 8'd19) begin
                mem[11]    <= 8'h0F;
                model_halt <= 1'b1;
            end
        end
        rd_data <= mem[bus.mem_addr];
    end

    assign bus.core_halt    = model_halt | force_halt;
    assign bus.mem_rd_data  = rd_data;
    assign bus2.core_halt   = 1'b1;
    assign bus2.mem_rd_data = 8'h00;
    assign bus2.out_ready   = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int out_cnt = 0;
    int out_valid_seen = 0;
    logic [15:0] exp_wr [$];
    logic [15:0] exp_wr2 [$];
    logic [7:0]  exp_out [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [15:0] e;
        if (bus.mem_wr_en) begin
            chk("wr_pending", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e[15:8]));
                chk("wr_data", 32'(bus.mem_wr_data), 32'(e[7:0]));
            end
        end
        if (bus2.mem_wr_en) begin
            chk("wr2_pending", 32'(exp_wr2.size() != 0), 1);
            if (exp_wr2.size() != 0) begin
                e = exp_wr2.pop_front();
                chk("wr2_addr", 32'(bus2.mem_addr), 32'(e[15:8]));
                chk("wr2_data", 32'(bus2.mem_wr_data), 32'(e[7:0]));
            end
        end
        if (bus.out_valid) out_valid_seen++;
        if (bus.out_valid && bus.out_ready) begin
            out_cnt++;
            chk("out_pending", 32'(exp_out.size() != 0), 1);
            if (exp_out.size() != 0) chk("out_data", 32'(bus.out_data), 32'(exp_out.pop_front()));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        chk("go_busy", 32'(bus.busy), 1);
        chk("go_done_clr", 32'(bus.done), 0);
        chk("go_terr_clr", 32'(bus.timeout_err), 0);
    endtask

    task automatic do_load(input bit sel, input ops_t ops, input int base, input int gap,
                           input bit pulse_go);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    if (pulse_go && i == 1 && g == 0) bus.go = 1'b1;
                    cyc();
                    bus.go = 1'b0;
                end
            end
            if (sel) begin
                chk("in_ready2", 32'(bus2.in_ready), 1);
                exp_wr2.push_back({8'(base + i), ops[i]});
                bus2.in_valid = 1'b1;
                bus2.in_data  = ops[i];
            end else begin
                chk("in_ready", 32'(bus.in_ready), 1);
                exp_wr.push_back({8'(base + i), ops[i]});
                bus.in_valid = 1'b1;
                bus.in_data  = ops[i];
            end
            cyc();
            bus.in_valid  = 1'b0;
            bus2.in_valid = 1'b0;
        end
    endtask

    task automatic launch_check();
        chk("launch_cs1", 32'(bus.core_start), 1);
        chk("launch_sel", 32'(bus.mem_sel), 0);
        chk("launch_inrdy", 32'(bus.in_ready), 0);
        cyc();
        chk("launch_cs2", 32'(bus.core_start), 1);
        cyc();
        chk("run_cs", 32'(bus.core_start), 0);
        chk("run_sel", 32'(bus.mem_sel), 0);
    endtask

    task automatic wait_done(input int bp_byte);
        logic [7:0] hold;
        bit bp_done = 1'b0;
        int k;
        for (k = 0; k < 400; k++) begin
            if (bus.done) break;
            if (!bp_done && bus.out_valid && out_cnt == bp_byte) begin
                bp_done = 1'b1;
                bus.out_ready = 1'b0;
                hold = bus.out_data;
                for (int s = 0; s < 5; s++) begin
                    cyc();
                    chk("bp_valid", 32'(bus.out_valid), 1);
                    chk("bp_data", 32'(bus.out_data), 32'(hold));
                end
                bus.out_ready = 1'b1;
            end
            cyc();
        end
        chk("done_in_time", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        ops_t ops;
        int n;
        bus.go = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus2.go = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0;
        core_mode = 0;
        force_halt = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_cs", 32'(bus.core_start), 1);
        chk("rst_sel", 32'(bus.mem_sel), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_terr", 32'(bus.timeout_err), 0);
        chk("rst_inrdy", 32'(bus.in_ready), 0);
        chk("rst_oval", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        cyc();

        // Normal job with result backpressure on byte 2.
        ops = '{8'h00, 8'h03, 8'h00, 8'h00};
        exp_out.push_back(8'h00); exp_out.push_back(8'h03);
        exp_out.push_back(8'h00); exp_out.push_back(8'h0F);
        out_cnt = 0;
        start_job();
        do_load(1'b0, ops, 8, 0, 1'b0);
        chk("mem8", 32'(mem[8]), 32'h00);
        chk("mem9", 32'(mem[9]), 32'h03);
        chk("mem10", 32'(mem[10]), 32'h00);
        chk("mem11", 32'(mem[11]), 32'h00);
        launch_check();
        wait_done(2);
        chk("j1_count", 32'(out_cnt), 4);
        chk("j1_q_empty", 32'(exp_out.size()), 0);
        chk("j1_terr", 32'(bus.timeout_err), 0);
        chk("j1_cs", 32'(bus.core_start), 1);

        // Timeout: core never halts.
        core_mode = 1;
        out_valid_seen = 0;
        ops = '{8'h05, 8'h06, 8'h07, 8'h08};
        start_job();
        do_load(1'b0, ops, 8, 0, 1'b0);
        launch_check();
        n = 0;
        while (bus.core_start === 1'b0 && n < 200) begin
            n++;
            cyc();
        end
        chk("to_run_cycles", 32'(n), 64);
        chk("to_terr", 32'(bus.timeout_err), 1);
        chk("to_done", 32'(bus.done), 1);
        chk("to_busy", 32'(bus.busy), 0);
        chk("to_sel", 32'(bus.mem_sel), 1);
        repeat (3) cyc();
        chk("to_no_out", 32'(out_valid_seen), 0);

        // Reset mid-run, then a fresh job.
        core_mode = 0;
        ops = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_job();
        do_load(1'b0, ops, 8, 0, 1'b0);
        launch_check();
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        chk("mr_cs", 32'(bus.core_start), 1);
        chk("mr_sel", 32'(bus.mem_sel), 1);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        repeat (30) cyc();
        chk("mr_no_out", 32'(out_cnt), 4);
        ops = '{8'h5A, 8'hC3, 8'h7E, 8'h99};
        exp_out.push_back(8'h5A); exp_out.push_back(8'hC3);
        exp_out.push_back(8'h7E); exp_out.push_back(8'h0F);
        out_cnt = 0;
        start_job();
        do_load(1'b0, ops, 8, 0, 1'b0);
        launch_check();
        wait_done(-1);
        chk("j3_count", 32'(out_cnt), 4);
        chk("j3_q_empty", 32'(exp_out.size()), 0);

        // Halt held high through launch; gapped operands; stray go during load.
        core_mode = 1;
        force_halt = 1'b1;
        ops = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_out.push_back(8'hA1); exp_out.push_back(8'hB2);
        exp_out.push_back(8'hC3); exp_out.push_back(8'hD4);
        out_cnt = 0;
        start_job();
        do_load(1'b0, ops, 8, 3, 1'b1);
        chk("gap_wr_all", 32'(exp_wr.size()), 0);
        chk("gap_busy", 32'(bus.busy), 1);
        launch_check();
        cyc();
        chk("hh_cs", 32'(bus.core_start), 1);
        chk("hh_sel", 32'(bus.mem_sel), 1);
        force_halt = 1'b0;
        wait_done(-1);
        chk("j4_count", 32'(out_cnt), 4);
        chk("j4_terr", 32'(bus.timeout_err), 0);
        chk("j4_q_empty", 32'(exp_out.size()), 0);

        // Address wrap on the second instance.
        ops = '{8'h01, 8'h02, 8'h03, 8'h04};
        bus2.go = 1'b1;
        cyc();
        bus2.go = 1'b0;
        do_load(1'b1, ops, 254, 0, 1'b0);
        n = 0;
        while (!bus2.done && n < 200) begin
            n++;
            cyc();
        end
        chk("wrap_done", 32'(bus2.done), 1);
        chk("wrap_wr_all", 32'(exp_wr2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_host_ctrl.md
Name: prog_host_ctrl

Overview:
Synthesizable host-side sequencer that drives the core's start/halt launch protocol. It is the initiator; TopLevel is the responder.
- Streams operand bytes into data memory, holds then releases core start, and waits for halt (with timeout).
- Reads result bytes back out of data memory and streams them to an output port.
- Sits beside TopLevel and owns the data-memory port whenever the core is held.

Parameters:
AW, 8, data-memory address width
DW, 8, data width
LOAD_BASE, 8, first memory address written with operands
LOAD_LEN, 4, operand bytes per job (0 allowed)
RESULT_BASE, 8, first memory address read back
RESULT_LEN, 4, result bytes per job (>=1)
HOLD_CYCLES, 2, cycles core_start is held high before release (>=1)
TIMEOUT, 4096, max RUN cycles before abort (counter 16 bits)

Ports:
CLK  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
go  in  1  job request; sampled only in IDLE
busy  out  1  high from go acceptance until return to IDLE
in_valid  in  1  operand byte valid
in_data  in  DW  operand byte
in_ready  out  1  operand accepted when in_valid&in_ready
out_valid  out  1  result byte valid
out_data  out  DW  result byte
out_ready  in  1  result accepted when out_valid&out_ready
core_start  out  1  to TopLevel start; 1 = core held, falling edge launches
core_halt  in  1  from TopLevel halt
mem_sel  out  1  1 = host owns data-memory port, 0 = core owns it
mem_addr  out  AW  host memory address
mem_wr_en  out  1  host write strobe
mem_wr_data  out  DW  host write data
mem_rd_data  in  DW  read data, valid the cycle after mem_addr is presented
done  out  1  job finished; sticky until next accepted go
timeout_err  out  1  last job aborted on timeout; sticky until next accepted go

Behaviour:
Reset values: core_start=1, mem_sel=1, all other outputs 0; state=IDLE. Reset_n low in any state (including mid-RUN) returns all outputs to these values at the next edge, so the core is re-held.

States: IDLE, LOAD, LAUNCH, RUN, RD_ADDR, RD_OUT.
- IDLE: go=1 -> busy=1, done=0, timeout_err=0, idx=0. Next state is LOAD, or LAUNCH if LOAD_LEN=0. go is ignored while busy.
- LOAD: in_ready=1.
  - mem_wr_en=in_valid&in_ready (combinational), mem_addr=LOAD_BASE+idx modulo 2^AW (wraps), mem_wr_data=in_data.
  - idx increments per handshake; in_valid gaps stall without writes.
  - After the LOAD_LEN-th write -> LAUNCH.
- LAUNCH: mem_sel=0, core_start=1 for exactly HOLD_CYCLES cycles, then core_start=0 and enter RUN. core_halt is ignored in LAUNCH.
- RUN: core_start=0, cycle counter increments from 0.
  - core_halt=1 sampled (including the first RUN cycle) -> next edge core_start=1, mem_sel=1, idx=0, RD_ADDR.
  - If the counter reaches TIMEOUT-1 without halt -> core_start=1, mem_sel=1, timeout_err=1, done=1, busy=0, IDLE. No readout.
  - Halt on the same cycle as the timeout: halt wins.
- RD_ADDR: mem_addr=RESULT_BASE+idx modulo 2^AW -> RD_OUT next cycle.
- RD_OUT: capture mem_rd_data into out_data, out_valid=1.
  - out_data is stable until out_ready.
  - On handshake: idx++, out_valid=0. Return to RD_ADDR, or after the RESULT_LEN-th byte go to IDLE with done=1, busy=0.
  - Throughput: 1 byte per 2 cycles minimum.
- mem_wr_en=0 outside LOAD. in_ready=0 outside LOAD. out_valid=0 outside RD_OUT.

Test Plan:
- Load 00,03,00,00 (LOAD_BASE=8). Memory model addr 8..11 must hold 00,03,00,00. core_start is high 2 cycles after the last write, then low. Core model halts 20 cycles later after writing 0x0F at addr 11. Out stream must be 00,03,00,0F, then done=1, busy=0.
- Result backpressure: out_ready low for 5 cycles on byte 2 -> out_valid stays 1 and out_data stays constant. Exactly 4 bytes, no duplicates.
- TIMEOUT=64, core never halts -> after 64 RUN cycles core_start=1, timeout_err=1, done=1, no out_valid ever.
- reset_n low for 1 cycle mid-RUN -> next edge core_start=1, mem_sel=1, busy=0, done=0. A new go then runs a full job correctly.
- go pulsed during LOAD is ignored. in_valid with 3-cycle gaps -> exactly 4 writes at addrs 8,9,10,11. LOAD_BASE=254 variant writes 254,255,0,1.
- core_halt already high on the first RUN cycle -> readout starts. core_halt high during LAUNCH -> ignored, start still released.
